// File: rtl/mem_d_if.sv
// Snooped core data-memory port: request/accept from the core side, ack/tag from memory.
interface mem_d_if #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 11
);
    logic              mem_d_rd_w;
    logic [3:0]        mem_d_wr_w;
    logic [ADDR_W-1:0] mem_d_addr_w;
    logic [TAG_W-1:0]  mem_d_req_tag_w;
    logic              mem_d_accept_w;
    logic              mem_d_ack_w;
    logic              mem_d_error_w;
    logic [TAG_W-1:0]  mem_d_resp_tag_w;

    // Handshake: a request transfers on the rising edge where (rd | wr != 0) and accept
    // are both high; a response transfers on any edge where ack is high. There is no
    // backpressure on responses, and the tracker only observes, never drives.
    modport master (
        output mem_d_rd_w, mem_d_wr_w, mem_d_addr_w, mem_d_req_tag_w, mem_d_accept_w,
        output mem_d_ack_w, mem_d_error_w, mem_d_resp_tag_w
    );

    modport slave (
        input mem_d_rd_w, mem_d_wr_w, mem_d_addr_w, mem_d_req_tag_w, mem_d_accept_w,
        input mem_d_ack_w, mem_d_error_w, mem_d_resp_tag_w
    );
endinterface

// File: rtl/mem_d_txn_tracker.sv
// In-order outstanding-transaction scoreboard for the data-memory port; retires on ack
// and reports protocol errors as registered one-cycle pulses plus a sticky flag.
module mem_d_txn_tracker #(
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 11,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_d_if.slave                     mem_d,
    output logic [$clog2(DEPTH):0]     outstanding_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [TAG_W-1:0]           exp_tag_o,
    output logic [ADDR_W-1:0]          exp_addr_o,
    output logic                       exp_wr_o,
    output logic [31:0]                retired_o,
    output logic                       err_mismatch_o,
    output logic                       err_unexpected_o,
    output logic                       err_overflow_o,
    output logic                       err_illegal_o,
    output logic                       err_resp_o,
    output logic                       err_timeout_o,
    output logic                       err_sticky_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic              wr_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0] count_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;

    logic is_wr, both_req, push_req, push, pop;
    logic ev_mismatch, ev_unexpected, ev_overflow, ev_illegal, ev_resp, ev_timeout;
    logic [TAG_W-1:0]  head_tag_n;
    logic [ADDR_W-1:0] head_addr_n;
    logic              head_wr_n;

    always_comb begin
        is_wr    = |mem_d.mem_d_wr_w;
        both_req = mem_d.mem_d_rd_w & is_wr;
        push_req = (mem_d.mem_d_rd_w | is_wr) & mem_d.mem_d_accept_w & ~both_req;
        // Acks are judged against the state before the edge, so an ack racing the
        // first push into an empty scoreboard is unexpected.
        pop      = mem_d.mem_d_ack_w & ~empty_o;
        push     = push_req & (~full_o | pop);

        ev_illegal    = both_req & mem_d.mem_d_accept_w;
        ev_overflow   = push_req & full_o & ~pop;
        ev_unexpected = mem_d.mem_d_ack_w & empty_o;
        ev_mismatch   = pop & (mem_d.mem_d_resp_tag_w != exp_tag_o);
        ev_resp       = mem_d.mem_d_ack_w & mem_d.mem_d_error_w;

        count_n  = outstanding_o + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

        // The new head is the incoming request only when it lands in the slot the
        // read pointer moves to; otherwise it is already in storage.
        head_tag_n  = '0;
        head_addr_n = '0;
        head_wr_n   = 1'b0;
        if (count_n != '0) begin
            if (push && (wr_ptr == rd_ptr_n)) begin
                head_tag_n  = mem_d.mem_d_req_tag_w;
                head_addr_n = mem_d.mem_d_addr_w;
                head_wr_n   = is_wr;
            end else begin
                head_tag_n  = tag_mem[rd_ptr_n];
                head_addr_n = addr_mem[rd_ptr_n];
                head_wr_n   = wr_mem[rd_ptr_n];
            end
        end

        tmo_cnt_n = tmo_cnt;
        if (TIMEOUT == 0 || empty_o || pop) begin
            tmo_cnt_n = '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
        ev_timeout = (TIMEOUT != 0) && (tmo_cnt_n == TMO_MAX) && (tmo_cnt != TMO_MAX);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= mem_d.mem_d_req_tag_w;
            addr_mem[wr_ptr] <= mem_d.mem_d_addr_w;
            wr_mem[wr_ptr]   <= is_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            tmo_cnt          <= '0;
            outstanding_o    <= '0;
            full_o           <= 1'b0;
            empty_o          <= 1'b1;
            exp_tag_o        <= '0;
            exp_addr_o       <= '0;
            exp_wr_o         <= 1'b0;
            retired_o        <= '0;
            err_mismatch_o   <= 1'b0;
            err_unexpected_o <= 1'b0;
            err_overflow_o   <= 1'b0;
            err_illegal_o    <= 1'b0;
            err_resp_o       <= 1'b0;
            err_timeout_o    <= 1'b0;
            err_sticky_o     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr           <= rd_ptr_n;
            tmo_cnt          <= tmo_cnt_n;
            outstanding_o    <= count_n;
            full_o           <= (count_n == CNT_FULL);
            empty_o          <= (count_n == '0);
            exp_tag_o        <= head_tag_n;
            exp_addr_o       <= head_addr_n;
            exp_wr_o         <= head_wr_n;
            if (pop) retired_o <= retired_o + 32'd1;
            err_mismatch_o   <= ev_mismatch;
            err_unexpected_o <= ev_unexpected;
            err_overflow_o   <= ev_overflow;
            err_illegal_o    <= ev_illegal;
            err_resp_o       <= ev_resp;
            err_timeout_o    <= ev_timeout;
            err_sticky_o     <= err_sticky_o | ev_mismatch | ev_unexpected | ev_overflow
                                | ev_illegal | ev_resp | ev_timeout;
        end
    end
endmodule

// File: tb/tb_mem_d_txn_tracker.sv
// Directed bench for mem_d_txn_tracker (DEPTH=4, TIMEOUT=8) with immediate assertions.
module tb_mem_d_txn_tracker;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 11;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_d_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

    logic [$clog2(DEPTH):0] outstanding;
    logic full, empty, exp_wr;
    logic [TAG_W-1:0]  exp_tag;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0] retired;
    logic err_mismatch, err_unexpected, err_overflow, err_illegal, err_resp, err_timeout, err_sticky;

    int n_assert = 0;
    int n_fail   = 0;

    mem_d_txn_tracker #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .mem_d(bus),
        .outstanding_o(outstanding), .full_o(full), .empty_o(empty),
        .exp_tag_o(exp_tag), .exp_addr_o(exp_addr), .exp_wr_o(exp_wr),
        .retired_o(retired),
        .err_mismatch_o(err_mismatch), .err_unexpected_o(err_unexpected),
        .err_overflow_o(err_overflow), .err_illegal_o(err_illegal),
        .err_resp_o(err_resp), .err_timeout_o(err_timeout), .err_sticky_o(err_sticky)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_d_rd_w       = 1'b0;
        bus.mem_d_wr_w       = 4'h0;
        bus.mem_d_addr_w     = '0;
        bus.mem_d_req_tag_w  = '0;
        bus.mem_d_accept_w   = 1'b0;
        bus.mem_d_ack_w      = 1'b0;
        bus.mem_d_error_w    = 1'b0;
        bus.mem_d_resp_tag_w = '0;
    endtask

    task automatic set_req(input logic rd, input logic [3:0] wr, input logic [ADDR_W-1:0] addr,
                           input logic [TAG_W-1:0] tag);
        bus.mem_d_rd_w      = rd;
        bus.mem_d_wr_w      = wr;
        bus.mem_d_addr_w    = addr;
        bus.mem_d_req_tag_w = tag;
        bus.mem_d_accept_w  = 1'b1;
    endtask

    task automatic set_ack(input logic [TAG_W-1:0] tag, input logic err);
        bus.mem_d_ack_w      = 1'b1;
        bus.mem_d_error_w    = err;
        bus.mem_d_resp_tag_w = tag;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_outstanding"}, 64'(outstanding), 64'd0);
        chk({pfx, "_empty"}, 64'(empty), 64'd1);
        chk({pfx, "_full"}, 64'(full), 64'd0);
        chk({pfx, "_exp_tag"}, 64'(exp_tag), 64'd0);
        chk({pfx, "_exp_addr"}, 64'(exp_addr), 64'd0);
        chk({pfx, "_exp_wr"}, 64'(exp_wr), 64'd0);
        chk({pfx, "_retired"}, 64'(retired), 64'd0);
        chk({pfx, "_err_pulses"}, 64'({err_mismatch, err_unexpected, err_overflow,
                                      err_illegal, err_resp, err_timeout}), 64'd0);
        chk({pfx, "_sticky"}, 64'(err_sticky), 64'd0);
    endtask

    initial begin
        logic [TAG_W-1:0] drain_tags [4];
        drain_tags[0] = 11'd11; drain_tags[1] = 11'd12;
        drain_tags[2] = 11'd13; drain_tags[3] = 11'd15;

        do_reset();
        chk_reset_state("reset");

        // Three loads then in-order acks.
        for (int i = 1; i <= 3; i++) begin
            set_req(1'b1, 4'h0, 32'h100 + 32'(4 * (i - 1)), 11'(i));
            tick();
            idle();
            chk($sformatf("load%0d_outstanding", i), 64'(outstanding), 64'(i));
            chk($sformatf("load%0d_head", i), 64'(exp_tag), 64'd1);
        end
        chk("load_head_addr", 64'(exp_addr), 64'h100);
        chk("load_head_wr", 64'(exp_wr), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            set_ack(11'(i), 1'b0);
            tick();
            idle();
            chk($sformatf("ack%0d_outstanding", i), 64'(outstanding), 64'(3 - i));
            chk($sformatf("ack%0d_head", i), 64'(exp_tag), (i == 3) ? 64'd0 : 64'(i + 1));
            chk($sformatf("ack%0d_mismatch", i), 64'(err_mismatch), 64'd0);
        end
        chk("inorder_retired", 64'(retired), 64'd3);
        chk("inorder_empty", 64'(empty), 64'd1);
        chk("inorder_sticky", 64'(err_sticky), 64'd0);

        // Fill with stores, overflow once, then push+pop while full.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_req(1'b0, 4'hF, 32'h200 + 32'(4 * i), 11'(10 + i));
            tick();
            idle();
            chk($sformatf("st%0d_outstanding", i), 64'(outstanding), (i < 4) ? 64'(i + 1) : 64'd4);
            chk($sformatf("st%0d_full", i), 64'(full), (i >= 3) ? 64'd1 : 64'd0);
            chk($sformatf("st%0d_overflow", i), 64'(err_overflow), (i == 4) ? 64'd1 : 64'd0);
        end
        chk("full_head_wr", 64'(exp_wr), 64'd1);
        chk("full_head_addr", 64'(exp_addr), 64'h200);
        tick();
        chk("overflow_one_cycle", 64'(err_overflow), 64'd0);
        set_req(1'b0, 4'h3, 32'h300, 11'd15);
        set_ack(11'd10, 1'b0);
        tick();
        idle();
        chk("pushpop_full_outstanding", 64'(outstanding), 64'd4);
        chk("pushpop_full_full", 64'(full), 64'd1);
        chk("pushpop_full_errs", 64'({err_overflow, err_mismatch, err_unexpected}), 64'd0);
        chk("pushpop_full_head", 64'(exp_tag), 64'd11);
        chk("pushpop_full_retired", 64'(retired), 64'd1);
        for (int i = 0; i < 4; i++) begin
            set_ack(drain_tags[i], 1'b0);
            tick();
            idle();
            chk($sformatf("drain%0d_mismatch", i), 64'(err_mismatch), 64'd0);
            chk($sformatf("drain%0d_outstanding", i), 64'(outstanding), 64'(3 - i));
        end
        chk("drain_tail_addr_seen", 64'(empty), 64'd1);
        chk("drain_sticky", 64'(err_sticky), 64'd1);

        // Tag mismatch still pops.
        do_reset();
        set_req(1'b1, 4'h0, 32'h400, 11'd5);
        tick();
        idle();
        set_ack(11'd6, 1'b0);
        tick();
        idle();
        chk("mismatch_pulse", 64'(err_mismatch), 64'd1);
        chk("mismatch_empty", 64'(empty), 64'd1);
        chk("mismatch_sticky", 64'(err_sticky), 64'd1);
        chk("mismatch_retired", 64'(retired), 64'd1);
        tick();
        chk("mismatch_one_cycle", 64'(err_mismatch), 64'd0);

        // Unexpected ack, ack racing first push, illegal request, error response.
        do_reset();
        set_ack(11'd0, 1'b0);
        tick();
        idle();
        chk("unexp_pulse", 64'(err_unexpected), 64'd1);
        chk("unexp_retired", 64'(retired), 64'd0);
        set_req(1'b1, 4'h0, 32'h500, 11'd7);
        set_ack(11'd7, 1'b0);
        tick();
        idle();
        chk("race_unexp", 64'(err_unexpected), 64'd1);
        chk("race_outstanding", 64'(outstanding), 64'd1);
        chk("race_head", 64'(exp_tag), 64'd7);
        set_ack(11'd7, 1'b0);
        tick();
        idle();
        chk("race_pop_outstanding", 64'(outstanding), 64'd0);
        chk("race_pop_unexp", 64'(err_unexpected), 64'd0);
        set_req(1'b1, 4'hF, 32'h600, 11'd8);
        tick();
        idle();
        chk("illegal_pulse", 64'(err_illegal), 64'd1);
        chk("illegal_outstanding", 64'(outstanding), 64'd0);
        set_req(1'b1, 4'h0, 32'h700, 11'd9);
        tick();
        idle();
        chk("illegal_one_cycle", 64'(err_illegal), 64'd0);
        set_ack(11'd9, 1'b1);
        tick();
        idle();
        chk("resp_err_pulse", 64'(err_resp), 64'd1);
        chk("resp_err_others", 64'({err_mismatch, err_unexpected, err_overflow, err_illegal}), 64'd0);
        chk("resp_err_outstanding", 64'(outstanding), 64'd0);

        // Timeout fires once, eight cycles after the push, then reset mid-flight.
        do_reset();
        set_req(1'b1, 4'h0, 32'h800, 11'd20);
        tick();
        idle();
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("timeout_k%0d", k), 64'(err_timeout), (k == 8) ? 64'd1 : 64'd0);
        end
        chk("timeout_sticky", 64'(err_sticky), 64'd1);
        chk("timeout_still_held", 64'(outstanding), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("midrst");
        tick();
        chk("midrst_no_pulse", 64'({err_mismatch, err_unexpected, err_overflow,
                                    err_illegal, err_resp, err_timeout}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
